// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared constants and types for the ROM fetch arbiter.
// These are the port indices, the fixed read latency, and the stage-1 tag type.
package rom_arb_pkg;

    localparam logic ROM_PORT0       = 1'b0;
    localparam logic ROM_PORT1       = 1'b1;
    localparam int   ROM_ARB_LATENCY = 2;

    // Tag carried alongside the ROM read that is in flight.
    typedef struct packed {
        logic valid;
        logic port;
    } rom_p1_tag_t;

endpackage

// File: rtl/rom_rr_arbiter.sv
// rom_rr_arbiter: 2-way grant vector for the ROM fetch front-end.
// The default build is round robin, steered by the most recently granted port.
// When ROM_ARB_FIXED_PRIO_EN is defined, port 0 always wins and there is no i_last input.
import rom_arb_pkg::*;

module rom_rr_arbiter (
    input  logic [1:0] i_req,
`ifndef ROM_ARB_FIXED_PRIO_EN
    input  logic       i_last,
`endif
    output logic [1:0] o_grant
);

    // One-hot grant (or zero); a grant bit implies the matching request bit.
    always_comb begin
        o_grant = 2'b00;
`ifdef ROM_ARB_FIXED_PRIO_EN
        if (i_req[ROM_PORT0]) begin
            o_grant[ROM_PORT0] = 1'b1;
        end else if (i_req[ROM_PORT1]) begin
            o_grant[ROM_PORT1] = 1'b1;
        end
`else
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            // Contention: hand the cycle to the port that did not win last time.
            2'b11:   o_grant = (i_last == ROM_PORT1) ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
`endif
    end

endmodule

// File: rtl/rom_fetch_arb.sv
// rom_fetch_arb: a two-master read front-end for a synchronous single-port ROM.
// It issues one ROM read per cycle and returns each read's data two cycles after the grant.
// Optional macro: ROM_ARB_FIXED_PRIO_EN selects fixed priority, with port 0 always winning.
//
// Handshake: a master raises reqN, holds addrN stable, and keeps both until ackN is high.
// ackN is combinational and means the read was issued to the ROM in that cycle.
// A request that is withdrawn before it is acked is forgotten.
// Completion is signalled by a one-cycle rvalidN strobe. rdataN holds its value until the
// next completion for that port.
import rom_arb_pkg::*;

module rom_fetch_arb #(
    parameter int aw = 13,
    parameter int dw = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [aw-1:0] addr0,
    output logic          ack0,
    output logic          rvalid0,
    output logic [dw-1:0] rdata0,
    input  logic          req1,
    input  logic [aw-1:0] addr1,
    output logic          ack1,
    output logic          rvalid1,
    output logic [dw-1:0] rdata1,
    output logic          rom_ce,
    output logic [aw-1:0] rom_addr,
    input  logic [dw-1:0] rom_do
);

    logic [1:0]    w_req;
    logic [1:0]    w_grant;
    logic [aw-1:0] w_rom_addr;
    rom_p1_tag_t   r_p1;
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic [dw-1:0] r_rdata0;
    logic [dw-1:0] r_rdata1;

    // Requests are masked while reset is high, so nothing is acked during reset.
    assign w_req = {req1, req0} & {2{~rst}};

`ifndef ROM_ARB_FIXED_PRIO_EN
    logic r_last;

    // Remember which port was granted most recently; this steers the next contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= ROM_PORT1;
        end else if (rom_ce) begin
            r_last <= w_grant[ROM_PORT1];
        end
    end
`endif

    rom_rr_arbiter u_arb (
        .i_req   (w_req),
`ifndef ROM_ARB_FIXED_PRIO_EN
        .i_last  (r_last),
`endif
        .o_grant (w_grant)
    );

    assign ack0   = w_grant[ROM_PORT0];
    assign ack1   = w_grant[ROM_PORT1];
    assign rom_ce = |w_grant;

    // Address mux: drive the granted port's address, or 0 when no port is granted.
    always_comb begin
        w_rom_addr = '0;
        if (w_grant[ROM_PORT0]) begin
            w_rom_addr = addr0;
        end else if (w_grant[ROM_PORT1]) begin
            w_rom_addr = addr1;
        end
    end

    assign rom_addr = w_rom_addr;

    // Stage-1 tag: records which port owns the ROM data arriving next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p1 <= '0;
        end else begin
            r_p1.valid <= rom_ce;
            r_p1.port  <= w_grant[ROM_PORT1];
        end
    end

    // Steer the returning ROM data into the owning port's register and pulse its valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= r_p1.valid && (r_p1.port == ROM_PORT0);
            r_rvalid1 <= r_p1.valid && (r_p1.port == ROM_PORT1);
            if (r_p1.valid && (r_p1.port == ROM_PORT0)) begin
                r_rdata0 <= rom_do;
            end
            if (r_p1.valid && (r_p1.port == ROM_PORT1)) begin
                r_rdata1 <= rom_do;
            end
        end
    end

    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;

endmodule

// File: tb/tb_rom_fetch_arb.sv
// tb_rom_fetch_arb: directed, table-driven bench for rom_fetch_arb.
// It uses an 8 KiB ROM model with mem[a] = a[7:0] ^ 8'h5A.
// Expected values follow the ROM_ARB_FIXED_PRIO_EN setting of the build.
module tb_rom_fetch_arb;

    logic        clk;
    logic        rst;
    logic        req0;
    logic [12:0] addr0;
    logic        ack0;
    logic        rvalid0;
    logic [7:0]  rdata0;
    logic        req1;
    logic [12:0] addr1;
    logic        ack1;
    logic        rvalid1;
    logic [7:0]  rdata1;
    logic        rom_ce;
    logic [12:0] rom_addr;
    logic [7:0]  rom_do;

    int n_cmp;
    int n_err;

    rom_fetch_arb #(.aw(13), .dw(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .addr0    (addr0),
        .ack0     (ack0),
        .rvalid0  (rvalid0),
        .rdata0   (rdata0),
        .req1     (req1),
        .addr1    (addr1),
        .ack1     (ack1),
        .rvalid1  (rvalid1),
        .rdata1   (rdata1),
        .rom_ce   (rom_ce),
        .rom_addr (rom_addr),
        .rom_do   (rom_do)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: registered read, so data is valid the cycle after rom_ce.
    logic [7:0] mem [0:8191];
    initial begin
        for (int a = 0; a < 8192; a++) begin
            mem[a] = 8'(a) ^ 8'h5A;
        end
    end
    always @(posedge clk) begin
        if (rom_ce) rom_do <= mem[rom_addr];
    end

    typedef struct {
        logic        rst;
        logic        req0;
        logic [12:0] addr0;
        logic        req1;
        logic [12:0] addr1;
        logic        ack0;
        logic        ack1;
        logic        ce;
        logic [12:0] raddr;
        logic        rv0;
        logic        rv1;
        logic [7:0]  rd0;
        logic [7:0]  rd1;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic q0, input logic [12:0] a0,
                       input logic q1, input logic [12:0] a1,
                       input logic k0, input logic k1, input logic ce,
                       input logic [12:0] ra, input logic v0, input logic v1,
                       input logic [7:0] d0, input logic [7:0] d1);
        vec_t v;
        v.rst = r;  v.req0 = q0; v.addr0 = a0; v.req1 = q1; v.addr1 = a1;
        v.ack0 = k0; v.ack1 = k1; v.ce = ce; v.raddr = ra;
        v.rv0 = v0; v.rv1 = v1; v.rd0 = d0; v.rd1 = d1;
        vecs.push_back(v);
    endtask

    task automatic idle(input logic v0, input logic v1,
                        input logic [7:0] d0, input logic [7:0] d1);
        add(1'b0, 1'b0, 13'h0, 1'b0, 13'h0, 1'b0, 1'b0, 1'b0, 13'h0, v0, v1, d0, d1);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic q0, input logic [12:0] a0,
                         input logic q1, input logic [12:0] a1);
        rst = r; req0 = q0; addr0 = a0; req1 = q1; addr1 = a1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        drive(1'b1, 1'b0, 13'h0, 1'b0, 13'h0);

        // Build the vector table: one record per clock cycle.
        // c0: requests raised during reset must not be acked.
        add(1, 1, 13'h010, 1, 13'h020, 0, 0, 0, 13'h0, 0, 0, 8'h00, 8'h00);
        // c1..c5: contention on addresses 1 and 2; c5 keeps only port 1 requesting.
        add(0, 1, 13'h001, 1, 13'h002, 1, 0, 1, 13'h001, 0, 0, 8'h00, 8'h00);
`ifdef ROM_ARB_FIXED_PRIO_EN
        add(0, 1, 13'h001, 1, 13'h002, 1, 0, 1, 13'h001, 0, 0, 8'h00, 8'h00);
        add(0, 1, 13'h001, 1, 13'h002, 1, 0, 1, 13'h001, 1, 0, 8'h5B, 8'h00);
        add(0, 1, 13'h001, 1, 13'h002, 1, 0, 1, 13'h001, 1, 0, 8'h5B, 8'h00);
        add(0, 0, 13'h000, 1, 13'h002, 0, 1, 1, 13'h002, 1, 0, 8'h5B, 8'h00);
        idle(1, 0, 8'h5B, 8'h00);
        idle(0, 1, 8'h5B, 8'h58);
`else
        add(0, 1, 13'h001, 1, 13'h002, 0, 1, 1, 13'h002, 0, 0, 8'h00, 8'h00);
        add(0, 1, 13'h001, 1, 13'h002, 1, 0, 1, 13'h001, 1, 0, 8'h5B, 8'h00);
        add(0, 1, 13'h001, 1, 13'h002, 0, 1, 1, 13'h002, 0, 1, 8'h5B, 8'h58);
        add(0, 0, 13'h000, 1, 13'h002, 0, 1, 1, 13'h002, 1, 0, 8'h5B, 8'h58);
        idle(0, 1, 8'h5B, 8'h58);
        idle(0, 1, 8'h5B, 8'h58);
`endif
        idle(0, 0, 8'h5B, 8'h58);
        // c9..c14: back-to-back reads on port 1.
        add(0, 0, 13'h000, 1, 13'h100, 0, 1, 1, 13'h100, 0, 0, 8'h5B, 8'h58);
        add(0, 0, 13'h000, 1, 13'h101, 0, 1, 1, 13'h101, 0, 0, 8'h5B, 8'h58);
        add(0, 0, 13'h000, 1, 13'h102, 0, 1, 1, 13'h102, 0, 1, 8'h5B, 8'h5A);
        idle(0, 1, 8'h5B, 8'h5B);
        idle(0, 1, 8'h5B, 8'h58);
        idle(0, 0, 8'h5B, 8'h58);
        // c15..c20: single read on port 0; the data must still hold at T+5.
        add(0, 1, 13'h010, 0, 13'h000, 1, 0, 1, 13'h010, 0, 0, 8'h5B, 8'h58);
        idle(0, 0, 8'h5B, 8'h58);
        idle(1, 0, 8'h4A, 8'h58);
        idle(0, 0, 8'h4A, 8'h58);
        idle(0, 0, 8'h4A, 8'h58);
        idle(0, 0, 8'h4A, 8'h58);
        // c21..c27: reset while a port 0 read is in flight, then contention after reset.
        add(0, 1, 13'h033, 0, 13'h000, 1, 0, 1, 13'h033, 0, 0, 8'h4A, 8'h58);
        add(1, 0, 13'h000, 0, 13'h000, 0, 0, 0, 13'h000, 0, 0, 8'h4A, 8'h58);
        add(0, 1, 13'h001, 1, 13'h002, 1, 0, 1, 13'h001, 0, 0, 8'h00, 8'h00);
        add(0, 0, 13'h000, 1, 13'h002, 0, 1, 1, 13'h002, 0, 0, 8'h00, 8'h00);
        idle(1, 0, 8'h5B, 8'h00);
        idle(0, 1, 8'h5B, 8'h58);
        idle(0, 0, 8'h5B, 8'h58);

        // Check the state after two cycles of reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ack0",     32'(ack0),     32'h0);
        check("reset ack1",     32'(ack1),     32'h0);
        check("reset rom_ce",   32'(rom_ce),   32'h0);
        check("reset rom_addr", 32'(rom_addr), 32'h0);
        check("reset rvalid0",  32'(rvalid0),  32'h0);
        check("reset rvalid1",  32'(rvalid1),  32'h0);
        check("reset rdata0",   32'(rdata0),   32'h0);
        check("reset rdata1",   32'(rdata1),   32'h0);

        // Apply the table: drive after the rising edge, sample at the falling edge.
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].rst, vecs[i].req0, vecs[i].addr0, vecs[i].req1, vecs[i].addr1);
            @(negedge clk);
            check($sformatf("c%0d ack0", i),     32'(ack0),     32'(vecs[i].ack0));
            check($sformatf("c%0d ack1", i),     32'(ack1),     32'(vecs[i].ack1));
            check($sformatf("c%0d rom_ce", i),   32'(rom_ce),   32'(vecs[i].ce));
            check($sformatf("c%0d rom_addr", i), 32'(rom_addr), 32'(vecs[i].raddr));
            check($sformatf("c%0d rvalid0", i),  32'(rvalid0),  32'(vecs[i].rv0));
            check($sformatf("c%0d rvalid1", i),  32'(rvalid1),  32'(vecs[i].rv1));
            check($sformatf("c%0d rdata0", i),   32'(rdata0),   32'(vecs[i].rd0));
            check($sformatf("c%0d rdata1", i),   32'(rdata1),   32'(vecs[i].rd1));
        end

        // Idle stretch: no ROM activity and no strobes for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            drive(1'b0, 1'b0, 13'h0, 1'b0, 13'h0);
            @(negedge clk);
            check($sformatf("idle%0d rom_ce", i),   32'(rom_ce),   32'h0);
            check($sformatf("idle%0d rom_addr", i), 32'(rom_addr), 32'h0);
            check($sformatf("idle%0d rvalid0", i),  32'(rvalid0),  32'h0);
            check($sformatf("idle%0d rvalid1", i),  32'(rvalid1),  32'h0);
        end

        // Top address on port 1, with bounded waits for the ack and the completion.
        begin
            int  budget;
            bit  seen;
            seen = 1'b0;
            @(posedge clk);
            #1;
            drive(1'b0, 1'b0, 13'h0, 1'b1, 13'h1FFF);
            for (budget = 0; budget < 4 && !seen; budget++) begin
                @(negedge clk);
                if (ack1) begin
                    seen = 1'b1;
                    check("max addr rom_addr", 32'(rom_addr), 32'h1FFF);
                end
                @(posedge clk);
                #1;
                if (seen) drive(1'b0, 1'b0, 13'h0, 1'b0, 13'h0);
            end
            check("max addr ack seen", 32'(seen), 32'h1);
            drive(1'b0, 1'b0, 13'h0, 1'b0, 13'h0);
            seen = 1'b0;
            for (budget = 0; budget < 4 && !seen; budget++) begin
                @(negedge clk);
                if (rvalid1) begin
                    seen = 1'b1;
                    check("max addr rdata1", 32'(rdata1), 32'hA5);
                end
            end
            check("max addr rvalid1 seen", 32'(seen), 32'h1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rom_fetch_arb.md
# rom_fetch_arb

Two-requester read front-end for a synchronous single-port ROM: registered read address, data valid one cycle after chip enable. Arbitrates per-cycle between two read masters (port 0, e.g. VIC character fetch; port 1, e.g. CPU/bus-bridge fetch). Drives the ROM's `ce`/`addr`, captures its data output, and returns it to the granted master with a per-port valid strobe and held data register. Fully pipelined: one ROM read issued per cycle.

## Interface
- `aw`, 13: ROM address width (8 KiB ROM).
- `dw`, 8: ROM data width.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0`  in  1  port 0 read request; held until `ack0`.
- `addr0`  in  aw  port 0 address; stable while `req0` is high.
- `ack0`  out  1  port 0 request accepted this cycle (combinational).
- `rvalid0`  out  1  one-cycle strobe: `rdata0` updated.
- `rdata0`  out  dw  port 0 read data; holds until the next port 0 completion.
- `req1`, `addr1`, `ack1`, `rvalid1`, `rdata1`: same as port 0, for port 1.
- `rom_ce`  out  1  to ROM `ce`; high in every grant cycle.
- `rom_addr`  out  aw  to ROM `addr`; granted address, 0 when idle.
- `rom_do`  in  dw  from ROM data output; valid the cycle after `rom_ce`.
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.

## Operation
- Grant logic (cycle T): at most one ack per cycle. `ackN = reqN & grantN`. `rom_ce = ack0 | ack1`. `rom_addr` = the granted port's address.
- Arbitration without the macro: 2-way round robin. `last` register records the most recently granted port.
  - Only one port requesting: that port is granted.
  - Both requesting: the port ≠ `last` is granted.
  - `last` updates only in grant cycles.
  - Reset value of `last` = 1, so port 0 wins the first contention.
- Pipeline: stage-1 register `{p1_valid, p1_port}` loads `{rom_ce, granted port}` at the end of T. In T+1, `rom_do` is the data for that read. At the end of T+1, if `p1_valid`:
  - `rdata<p1_port>` <= `rom_do`.
  - `rvalid<p1_port>` <= 1.
  - All other `rvalid` bits <= 0.
- Back-to-back: a port may be re-granted in T+1 while its T read is in flight. Completions return in grant order, one per cycle, never merged.
- A request deasserted without an ack is dropped silently. No state is kept for un-acked requests.
- Reset values: `ack*`=0 (given `req*`=0), `rvalid*`=0, `rdata*`=0, `rom_ce`=0, `rom_addr`=0, `p1_valid`=0, `last`=1.
- Reset mid-operation: in-flight stage-1 read is discarded. No `rvalid` asserts in the cycle after reset release for a pre-reset grant. `rdata*` clear to 0.
- `req*` asserted during reset: not acked while `rst` is high.

## Timing
- Latency: grant at T → `rvalid` high and `rdata` valid in T+2. `rdata` remains stable afterwards until overwritten.
- Throughput: 1 read/cycle aggregate.
  - Round robin, both ports requesting continuously: each port gets 1 grant per 2 cycles.
- `ack*`, `rom_ce`, `rom_addr` are combinational from `req*`, `addr*`, `last`, `rst`. No combinational path from `rom_do` to any output.
- `rvalid*` and `rdata*` are registered.

## Configuration
- `ROM_ARB_FIXED_PRIO_EN` defined: fixed priority.
  - Port 0 always wins contention; `last` is not implemented.
  - Port 1 is granted only in cycles with `req0`=0.
  - Used when port 0 is a hard-real-time video fetch.
- Undefined: round robin as specified above.

## Structure
- Shared package `rom_arb_pkg`:
  - port index constants `ROM_PORT0`=0, `ROM_PORT1`=1.
  - `ROM_ARB_LATENCY`=2.
  - typedef for the stage-1 tag `{valid, port}`.
- One sub-module, `rom_rr_arbiter`: 2-way grant vector from `req` and `last`, honouring `ROM_ARB_FIXED_PRIO_EN`.
- Top level holds the mux, the stage-1 register and the per-port output registers.

## Test plan
Bench instantiates an 8 KiB ROM model with `mem[a] = a[7:0] ^ 8'h5A`.

- Single read: `req0`=1, `addr0`=13'h0010 for one cycle at T.
  - `ack0`=1 at T; `rvalid0`=1 at T+2 with `rdata0`=8'h4A.
  - `rdata0` still 8'h4A at T+5.
- Contention (round robin): `req0`=`req1`=1 held 4 cycles, `addr0`=13'h0001, `addr1`=13'h0002.
  - Grants alternate 0,1,0,1.
  - `rvalid0` at T+2 and T+4 with 8'h5B; `rvalid1` at T+3 and T+5 with 8'h58.
- Fixed priority (`ROM_ARB_FIXED_PRIO_EN` defined), same stimulus:
  - `ack0`=1 every cycle, `ack1`=0 throughout.
  - After `req0` drops, `ack1` the next cycle and `rdata1`=8'h58 two cycles later.
- Back-to-back single port: `req1`=1 for 3 cycles with `addr1` = 13'h0100, 13'h0101, 13'h0102.
  - `rvalid1` high for 3 consecutive cycles.
  - Data 8'h5A, 8'h5B, 8'h58.
- Reset mid-flight: grant port 0 at T, `rst`=1 at T+1 for one cycle.
  - No `rvalid0` at T+2; `rdata0`=0.
  - The first contention after reset goes to port 0.
- Idle: no requests for 10 cycles.
  - `rom_ce`=0, `rom_addr`=0, `rvalid*`=0 throughout.
